param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 8, number of entries (power of two, >=2).
REQ-003 The block SHALL have parameter AF_LVL, default DEPTH-2, almost_full threshold (1..DEPTH-1).
REQ-004 The block SHALL have parameter AE_LVL, default 2, almost_empty threshold (1..DEPTH-1).
REQ-005 The block SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port wen  input  1  write request.
REQ-008 The block SHALL have port data_in  input  DATA_W  write data.
REQ-009 The block SHALL have port ren  input  1  read request.
REQ-010 The block SHALL have port clr_err  input  1  synchronous clear of sticky error flags.
REQ-011 The block SHALL have port data_out  output  DATA_W  read data.
REQ-012 The block SHALL have port empty, full, almost_empty, almost_full  output  1 each  status flags.
REQ-013 The block SHALL have port count  output  log2(DEPTH)+1  current occupancy 0..DEPTH.
REQ-014 The block SHALL have port overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 Write SHALL be accepted on an edge when wen=1 and (full=0 or read accepted same edge); data_in stored at wptr, wptr increments modulo DEPTH.
REQ-016 Read SHALL be accepted on an edge when ren=1 and empty=0; rptr increments modulo DEPTH.
REQ-017 Simultaneous accepted read and write SHALL leave count unchanged, including when full (write into slot freed by read).
REQ-018 When empty and wen=ren=1, the read SHALL be rejected and the write accepted (count 0->1); no write-to-read bypass.
REQ-019 count SHALL be +1 on write-only, -1 on read-only, and never exceed DEPTH nor drop below 0.
REQ-020 empty=(count==0), full=(count==DEPTH), almost_full=(count>=AF_LVL), almost_empty=(count<=AE_LVL), all decoded from registered count.
REQ-021 Pointers SHALL wrap from DEPTH-1 to 0 without data loss or reordering.
REQ-022 overflow SHALL set on the edge where wen=1, full=1, ren=0; underflow SHALL set where ren=1, empty=1.
REQ-023 overflow/underflow SHALL hold until clr_err=1 on an edge; a set event in the same cycle as clr_err SHALL win.
REQ-024 Rejected writes/reads SHALL not modify memory, pointers, count or data_out.

Reset
REQ-025 rst=0 SHALL asynchronously force rptr=0, wptr=0, count=0, data_out=0, overflow=0, underflow=0; memory contents not reset.
REQ-026 Reset asserted mid-operation SHALL discard all stored entries; after release empty=1, almost_empty=1, full=0, almost_full=0.

Configuration
REQ-027 Macro PARAM_FIFO_FWFT_EN SHALL select first-word-fall-through read mode.
REQ-028 Without PARAM_FIFO_FWFT_EN: data_out SHALL be registered, updated with mem[rptr] on the edge a read is accepted (1-cycle latency), and hold otherwise.
REQ-029 With PARAM_FIFO_FWFT_EN: data_out SHALL present mem[rptr] whenever empty=0 (head visible without ren; ren=1 pops it), and 0 when empty=1.

Verification
REQ-030 Reset, write 0x11..0x18 (8 writes, DEPTH=8) -> full=1, count=8, almost_full=1 from count 6; read 8 -> data_out 0x11..0x18 in order, empty=1.
REQ-031 Full, wen=1 with data 0xAA, ren=0 -> overflow=1, count stays 8, 0xAA never read; clr_err=1 -> overflow=0 next edge.
REQ-032 Full, wen=ren=1 data 0x55 -> count stays 8, head popped, 0x55 read out as last of next 8 reads.
REQ-033 Empty, ren=1 -> underflow=1, data_out unchanged; empty with wen=ren=1 data 0x3C -> count=1, underflow set, 0x3C read next.
REQ-034 20 interleaved writes/reads with occupancy 3-5 -> pointer wrap twice, output sequence equals input sequence.
REQ-035 Write 3 words, assert rst=0 between edges -> count=0, empty=1, data_out=0 immediately; repeat REQ-030 with PARAM_FIFO_FWFT_EN defined, data_out=0x11 after first write without ren.

Source files
------------

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parameterised synchronous FIFO with status and sticky error flags
//
// Optional build macro: PARAM_FIFO_FWFT_EN (first-word-fall-through read mode).
//
// Parameters:
//   DATA_W  word width in bits
//   DEPTH   number of entries, power of two
//   AF_LVL  almost_full asserted when count >= AF_LVL
//   AE_LVL  almost_empty asserted when count <= AE_LVL
// Ports:
//   clk           clock, all state on rising edge
//   rst           asynchronous active-low reset
//   wen, data_in  write request and data
//   ren           read request
//   clr_err       synchronous clear of overflow/underflow
//   data_out      read data (registered, or head-of-queue in FWFT mode)
//   empty, full, almost_empty, almost_full  status decoded from count
//   count         occupancy 0..DEPTH
//   overflow, underflow  sticky error flags
module param_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     ren,
    input  logic                     clr_err,
    output logic [DATA_W-1:0]        data_out,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LVL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rptr;
    logic [AW-1:0]     wptr;
    logic [CW-1:0]     count_q;
    logic              rd_acc;
    logic              wr_acc;
    logic              ovf_set;
    logic              udf_set;

    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_CNT);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;

    // A write to a full FIFO still lands when the same edge pops a word,
    // because it reuses the slot just freed. No write-to-read bypass when empty.
    assign rd_acc  = ren && !empty;
    assign wr_acc  = wen && (!full || rd_acc);
    assign ovf_set = wen && full && !ren;
    assign udf_set = ren && empty;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr      <= '0;
            wptr      <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (wr_acc) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_acc) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            // A new error event beats a clear in the same cycle.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (udf_set) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef PARAM_FIFO_FWFT_EN
    // Head word is visible without a read; forced to zero while empty so
    // stale memory never shows after reset or drain.
    assign data_out = empty ? '0 : mem[rptr];
`else
    logic [DATA_W-1:0] data_out_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_q <= '0;
        end else if (rd_acc) begin
            data_out_q <= mem[rptr];
        end
    end

    assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - self-checking bench for param_fifo against a queue model
module tb_param_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int AF_LVL = DEPTH - 2;
    localparam int AE_LVL = 2;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wen = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              ren = 1'b0;
    logic              clr_err = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: a plain queue of stored words plus the flag state.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] dout_m = '0;
    logic              ovf_m  = 1'b0;
    logic              udf_m  = 1'b0;

    param_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .AF_LVL(AF_LVL),
        .AE_LVL(AE_LVL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wen         (wen),
        .data_in     (data_in),
        .ren         (ren),
        .clr_err     (clr_err),
        .data_out    (data_out),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_dout();
`ifdef PARAM_FIFO_FWFT_EN
        return (q.size() != 0) ? q[0] : '0;
`else
        return dout_m;
`endif
    endfunction

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, ".count"},    32'(count),        32'(n));
        check({tag, ".empty"},    32'(empty),        32'(n == 0));
        check({tag, ".full"},     32'(full),         32'(n == DEPTH));
        check({tag, ".aempty"},   32'(almost_empty), 32'(n <= AE_LVL));
        check({tag, ".afull"},    32'(almost_full),  32'(n >= AF_LVL));
        check({tag, ".overflow"}, 32'(overflow),     32'(ovf_m));
        check({tag, ".underflow"},32'(underflow),    32'(udf_m));
        check({tag, ".data_out"}, 32'(data_out),     32'(exp_dout()));
    endtask

    // Called at a falling edge: drive, take one rising edge, advance the
    // model, then check at the next falling edge.
    task automatic step(input string tag, input logic w, input logic [DATA_W-1:0] d,
                        input logic r, input logic c);
        bit was_full, was_empty, rd, wr;
        wen = w; data_in = d; ren = r; clr_err = c;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        rd = r && !was_empty;
        wr = w && (!was_full || rd);
        if (w && was_full && !r) ovf_m = 1'b1;
        else if (c)              ovf_m = 1'b0;
        if (r && was_empty)      udf_m = 1'b1;
        else if (c)              udf_m = 1'b0;
        if (rd) dout_m = q.pop_front();
        if (wr) q.push_back(d);
        @(negedge clk);
        wen = 1'b0; ren = 1'b0; clr_err = 1'b0;
        check_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        dout_m = '0;
        ovf_m  = 1'b0;
        udf_m  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all("reset");
    endtask

    task automatic fill_seq(input string tag);
        for (int i = 0; i < DEPTH; i++) step(tag, 1'b1, DATA_W'(8'h11 + i), 1'b0, 1'b0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH; i++) step(tag, 1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        int bias;
        do_reset();

        // Fill 0x11..0x18 then drain in order.
        fill_seq("fill");
        drain("drain");

        // Overflow with 0xAA, sticky, then cleared.
        fill_seq("ovf_fill");
        step("ovf_push", 1'b1, 8'hAA, 1'b0, 1'b0);
        step("ovf_hold", 1'b0, '0, 1'b0, 1'b0);
        step("ovf_clr",  1'b0, '0, 1'b0, 1'b1);
        drain("ovf_drain");

        // Simultaneous read/write while full; 0x55 comes out last.
        fill_seq("rw_fill");
        step("rw_full", 1'b1, 8'h55, 1'b1, 1'b0);
        drain("rw_drain");

        // Underflow, then empty with wen=ren=1 (write wins), clear+set race.
        step("udf",      1'b0, '0, 1'b1, 1'b0);
        step("udf_wr",   1'b1, 8'h3C, 1'b1, 1'b0);
        step("udf_rd",   1'b0, '0, 1'b1, 1'b0);
        step("udf_race", 1'b0, '0, 1'b1, 1'b1);
        step("udf_clr",  1'b0, '0, 1'b0, 1'b1);

        // Interleaved traffic holding occupancy around 4, wrapping pointers.
        for (int i = 0; i < 4; i++) step("ilv_pre", 1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step("ilv_w", 1'b1, DATA_W'($urandom), 1'b0, 1'b0);
            step("ilv_r", 1'b0, '0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) step("ilv_post", 1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset between edges with data stored.
        for (int i = 0; i < 3; i++) step("ar_w", 1'b1, DATA_W'(8'hA0 + i), 1'b0, 1'b0);
        step("ar_r", 1'b0, '0, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("async_rst.count",    32'(count),    32'd0);
        check("async_rst.empty",    32'(empty),    32'd1);
        check("async_rst.data_out", 32'(data_out), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all("post_rst");

        // Randomised traffic with a drifting fill/drain bias.
        for (int i = 0; i < 1200; i++) begin
            if (i % 60 == 0) bias = $urandom_range(1, 3);
            step("rand",
                 ($urandom_range(0, 3) < bias),
                 DATA_W'($urandom),
                 ($urandom_range(0, 3) < (4 - bias)),
                 ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
